// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle divider.
//   div_state_t - divider FSM state
//   DIV_WIDTH   - default operand/result width
//   DIV_CNT_W   - iteration-counter width for DIV_WIDTH
//   cnt_width() - iteration-counter width for an arbitrary width
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StIter,
        StFix
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    function automatic int unsigned cnt_width(int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  - current partial remainder (always < dvs)
//   dvs     - divisor magnitude
//   bit_in  - next dividend bit, shifted into the partial remainder
//   rem_out - next partial remainder
//   q_bit   - quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvs,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, dvs});
        // The true difference is < dvs, so the low WIDTH bits of the
        // modular subtraction are exact.
        rem_out = q_bit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_core.sv
// div_core: multi-cycle signed/unsigned integer divider.
// Latches operands on start, converts to magnitudes, runs WIDTH restoring
// steps MSB first, then applies signs and error overrides. Fixed latency.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request, sampled only while idle
//   sign       - 1 = two's-complement signed, 0 = unsigned
//   a, b       - dividend, divisor
//   busy       - high from the cycle after acceptance through done
//   done       - one-cycle pulse, result/error valid and held afterwards
//   result     - quotient (truncated toward zero)
//   error      - divide-by-zero or signed overflow
//   remainder  - remainder, sign of dividend (only with DIV_REMAINDER_EN)
// Optional feature macro: DIV_REMAINDER_EN adds the remainder port.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_q;
    logic [WIDTH-1:0] quo_q;   // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem_q;
    logic             qneg_q, rneg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             error_q;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             last_iter;
    logic             div_zero, ovf;
    logic [WIDTH-1:0] fix_result;
    logic             fix_error;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (prem_q),
        .dvs    (dvs_q),
        .bit_in (quo_q[WIDTH-1]),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: state_d = StIter;
            StIter:  if (last_iter) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            quo_q    <= '0;
            dvs_q    <= '0;
            prem_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        sign_q <= sign;
                    end
                end
                StSetup: begin
                    quo_q  <= (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    dvs_q  <= (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    prem_q <= '0;
                    cnt_q  <= '0;
                    qneg_q <= sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_q <= sign_q & a_q[WIDTH-1];
                end
                StIter: begin
                    prem_q <= step_rem;
                    quo_q  <= {quo_q[WIDTH-2:0], step_q};
                    cnt_q  <= cnt_q + 1'b1;
                end
                StFix: begin
                    result_q <= fix_result;
                    error_q  <= fix_error;
                end
                default: ;
            endcase
        end
    end

    // Sign application and error overrides
    assign div_zero = (b_q == '0);
    assign ovf      = sign_q && (a_q == MOST_NEG) && (b_q == '1);

    always_comb begin
        fix_error  = div_zero | ovf;
        fix_result = qneg_q ? -quo_q : quo_q;
        if (div_zero) begin
            fix_result = '1;
        end else if (ovf) begin
            fix_result = MOST_NEG;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StFix);
    // Final values are visible during the done cycle and held in registers after.
    assign result = done ? fix_result : result_q;
    assign error  = done ? fix_error : error_q;

`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] fix_rem;

    always_comb begin
        fix_rem = rneg_q ? -prem_q : prem_q;
        if (div_zero) begin
            fix_rem = a_q;
        end else if (ovf) begin
            fix_rem = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else if (state_q == StFix) begin
            rem_q <= fix_rem;
        end
    end

    assign remainder = done ? fix_rem : rem_q;
`endif

endmodule

// File: tb/tb_div_core.sv
// tb_div_core: directed table-driven bench for div_core (WIDTH = 16).
// Cycle k is the clock period ending at the k-th rising edge after the
// accept edge; outputs are sampled on the falling edge inside that period.
module tb_div_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, error;
    logic [15:0] result;
`ifdef DIV_REMAINDER_EN
    logic [15:0] remainder;
`endif

    always #5 clk = ~clk;

    div_core #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .error (error)
`ifdef DIV_REMAINDER_EN
        ,
        .remainder(remainder)
`endif
    );

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        bit seen_done;
        int idle_q[$];
        int done_q[$];

        vecs[0]  = '{1'b0, 16'd100,  16'd2,    16'd50,   16'd0,    1'b0};
        vecs[1]  = '{1'b0, 16'd8,    16'd4,    16'd2,    16'd0,    1'b0};
        vecs[2]  = '{1'b0, 16'hFFFF, 16'd3,    16'h5555, 16'd0,    1'b0};
        vecs[3]  = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0};
        vecs[4]  = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0};
        vecs[5]  = '{1'b0, 16'd10,   16'd0,    16'hFFFF, 16'd10,   1'b1};
        vecs[6]  = '{1'b1, 16'd10,   16'd0,    16'hFFFF, 16'd10,   1'b1};
        vecs[7]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b1};
        vecs[8]  = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0};
        vecs[9]  = '{1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0};
        vecs[10] = '{1'b0, 16'h1234, 16'd100,  16'h002E, 16'h003C, 1'b0};
        vecs[11] = '{1'b1, 16'h8000, 16'd2,    16'hC000, 16'd0,    1'b0};
        vecs[12] = '{1'b1, 16'h8000, 16'd0,    16'hFFFF, 16'h8000, 1'b1};

        // Reset state
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset error", 32'(error), 32'd0);
`ifdef DIV_REMAINDER_EN
        check("reset remainder", 32'(remainder), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            sign  = vecs[i].s;
            a     = vecs[i].a;
            b     = vecs[i].b;
            start = 1'b1;
            @(posedge clk);
            #1;
            // Scramble inputs after acceptance; they must be ignored.
            start = 1'b0;
            a     = 16'hA5A5;
            b     = 16'h0001;
            sign  = ~sign;
            k = 0;
            while (k < 60) begin
                @(negedge clk);
                k++;
                if (done) break;
            end
            check($sformatf("v%0d latency", i), 32'(k), 32'd18);
            check($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].q));
            check($sformatf("v%0d error", i), 32'(error), 32'(vecs[i].e));
`ifdef DIV_REMAINDER_EN
            check($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
`endif
            check($sformatf("v%0d busy at done", i), 32'(busy), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d done pulse width", i), 32'(done), 32'd0);
            check($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d result held", i), 32'(result), 32'(vecs[i].q));
            check($sformatf("v%0d error held", i), 32'(error), 32'(vecs[i].e));
        end

        // Reset mid-operation (result currently holds 0xFFFF from the last vector)
        sign  = 1'b0;
        a     = 16'hFFFF;
        b     = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 9; j++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort no done", 32'(seen_done), 32'd0);
        check("abort idle", 32'(busy), 32'd0);

        // Back-to-back with start held high
        sign  = 1'b0;
        a     = 16'd100;
        b     = 16'd2;
        start = 1'b1;
        check("b2b idle at 0", 32'(busy), 32'd0);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (!busy) idle_q.push_back(j);
            if (done) done_q.push_back(j);
        end
        start = 1'b0;
        check("b2b idle count", 32'(idle_q.size()), 32'd2);
        check("b2b accept 1", (idle_q.size() > 0) ? 32'(idle_q[0]) : 32'hFFFF_FFFF, 32'd19);
        check("b2b accept 2", (idle_q.size() > 1) ? 32'(idle_q[1]) : 32'hFFFF_FFFF, 32'd38);
        check("b2b done count", 32'(done_q.size()), 32'd2);
        check("b2b done 1", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd18);
        check("b2b done 2", (done_q.size() > 1) ? 32'(done_q[1]) : 32'hFFFF_FFFF, 32'd37);
        check("b2b result", 32'(result), 32'd50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
